// File: rtl/zp_bp_cfg_boot_sequencer_if.sv
// cfg-bus request/response bundle between the boot sequencer (master side)
// and the BlackParrot cfg-bus / IO request path (slave side).
interface zp_bp_cfg_boot_sequencer_if #(
  parameter int cfg_addr_width_p = 20,
  parameter int cfg_data_width_p = 64
);
  logic                        req_v_o;
  logic                        req_w_o;
  logic [cfg_addr_width_p-1:0] req_addr_o;
  logic [cfg_data_width_p-1:0] req_data_o;
  logic                        req_ready_and_i;
  logic                        resp_v_i;
  logic                        resp_err_i;
  logic [cfg_data_width_p-1:0] resp_data_i;
  logic                        resp_yumi_o;

  modport master (
    output req_v_o, req_w_o, req_addr_o, req_data_o, resp_yumi_o,
    input  req_ready_and_i, resp_v_i, resp_err_i, resp_data_i
  );

  modport slave (
    input  req_v_o, req_w_o, req_addr_o, req_data_o, resp_yumi_o,
    output req_ready_and_i, resp_v_i, resp_err_i, resp_data_i
  );
endinterface

// File: rtl/zp_bp_cfg_boot_sequencer.sv
// Boot sequencer: on a host start pulse, freezes and programs every core
// through the BP cfg bus (freeze, npc, icache, dcache, cce modes), then
// writes freeze=0 to every core. One request outstanding at a time.
// Optional build macro ZP_CFG_SEQ_READBACK_EN: each programming write is
// followed by a read of the same address and the data is compared.
module zp_bp_cfg_boot_sequencer #(
  parameter int num_core_p       = 1,
  parameter int cfg_addr_width_p = 20,
  parameter int cfg_data_width_p = 64,
  parameter int core_stride_lg_p = 16,
  parameter logic [cfg_addr_width_p-1:0] freeze_addr_p      = 20'h00008,
  parameter logic [cfg_addr_width_p-1:0] npc_addr_p         = 20'h00010,
  parameter logic [cfg_addr_width_p-1:0] icache_mode_addr_p = 20'h00020,
  parameter logic [cfg_addr_width_p-1:0] dcache_mode_addr_p = 20'h00028,
  parameter logic [cfg_addr_width_p-1:0] cce_mode_addr_p    = 20'h00030,
  parameter int timeout_p        = 4096
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        start_i,
  input  logic [cfg_data_width_p-1:0] npc_i,
  input  logic [1:0]                  icache_mode_i,
  input  logic [1:0]                  dcache_mode_i,
  input  logic                        cce_mode_i,
  zp_bp_cfg_boot_sequencer_if.master  cfg,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        error_o,
  output logic [3:0]                  err_core_o
);
  localparam int AW = cfg_addr_width_p;
  localparam int DW = cfg_data_width_p;
  localparam int CW = $clog2(num_core_p + 1);
  localparam int TW = $clog2(timeout_p + 1);
  localparam logic [CW-1:0] CORE_ONE  = CW'(1);
  localparam logic [CW-1:0] CORE_LAST = CW'(num_core_p - 1);
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(timeout_p - 1);
  localparam logic [2:0]    STEP_LAST = 3'd4;
  localparam logic [DW-1:0] DATA_ONE  = DW'(1);

  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE, ST_ERROR} state_t;

  state_t        r_state, w_state_n, w_adv_state;
  logic [CW-1:0] r_core, w_core_n, w_adv_core;
  logic [2:0]    r_step, w_step_n, w_adv_step;
  logic          r_rel, w_rel_n, w_adv_rel, w_adv_done;
  logic          r_rd, w_rd_n;
  logic [TW-1:0] r_tmo, w_tmo_n;
  logic          r_done, w_done_n, r_error, w_error_n;
  logic [3:0]    r_err_core, w_err_core_n;
  logic          w_load, w_last_core;
  logic [DW-1:0] r_npc, w_data;
  logic [1:0]    r_icm, r_dcm;
  logic          r_ccm;
  logic [AW-1:0] w_off;

  assign w_last_core = (r_core == CORE_LAST);

  // Register offset and write data for the current step (release writes clear freeze).
  always_comb begin
    w_off  = freeze_addr_p;
    w_data = '0;
    if (r_rel) begin
      w_off  = freeze_addr_p;
      w_data = '0;
    end else begin
      case (r_step)
        3'd0:    begin w_off = freeze_addr_p;      w_data = DATA_ONE;   end
        3'd1:    begin w_off = npc_addr_p;         w_data = r_npc;      end
        3'd2:    begin w_off = icache_mode_addr_p; w_data = DW'(r_icm); end
        3'd3:    begin w_off = dcache_mode_addr_p; w_data = DW'(r_dcm); end
        3'd4:    begin w_off = cce_mode_addr_p;    w_data = DW'(r_ccm); end
        default: begin w_off = freeze_addr_p;      w_data = '0;         end
      endcase
    end
  end

  // Position that follows a successfully completed step; never runs past the last core.
  always_comb begin
    w_adv_state = ST_ISSUE;
    w_adv_core  = r_core;
    w_adv_step  = r_step;
    w_adv_rel   = r_rel;
    w_adv_done  = 1'b0;
    if (r_rel) begin
      if (w_last_core) begin
        w_adv_state = ST_DONE;
        w_adv_done  = 1'b1;
      end else begin
        w_adv_core = r_core + CORE_ONE;
      end
    end else if (r_step == STEP_LAST) begin
      w_adv_step = 3'd0;
      if (w_last_core) begin
        w_adv_rel  = 1'b1;
        w_adv_core = '0;
      end else begin
        w_adv_core = r_core + CORE_ONE;
      end
    end else begin
      w_adv_step = r_step + 3'd1;
    end
  end

  // Next-state and sequencing decisions.
  always_comb begin
    w_state_n    = r_state;
    w_core_n     = r_core;
    w_step_n     = r_step;
    w_rel_n      = r_rel;
    w_rd_n       = r_rd;
    w_tmo_n      = r_tmo;
    w_done_n     = r_done;
    w_error_n    = r_error;
    w_err_core_n = r_err_core;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_i) begin
          w_load       = 1'b1;
          w_state_n    = ST_ISSUE;
          w_core_n     = '0;
          w_step_n     = 3'd0;
          w_rel_n      = 1'b0;
          w_rd_n       = 1'b0;
          w_tmo_n      = '0;
          w_done_n     = 1'b0;
          w_error_n    = 1'b0;
          w_err_core_n = 4'd0;
        end else begin
          w_state_n = r_state;
        end
      end
      ST_ISSUE: begin
        if (cfg.req_ready_and_i) begin
          w_state_n = ST_WAIT;
          w_tmo_n   = '0;
        end else begin
          w_state_n = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (cfg.resp_v_i) begin
          if (cfg.resp_err_i) begin
            w_state_n    = ST_ERROR;
            w_error_n    = 1'b1;
            w_err_core_n = 4'(r_core);
          end else begin
`ifdef ZP_CFG_SEQ_READBACK_EN
            if (!r_rd && !r_rel) begin
              w_rd_n    = 1'b1;
              w_state_n = ST_ISSUE;
            end else if (r_rd && (cfg.resp_data_i != w_data)) begin
              w_state_n    = ST_ERROR;
              w_error_n    = 1'b1;
              w_err_core_n = 4'(r_core);
            end else begin
              w_rd_n    = 1'b0;
              w_state_n = w_adv_state;
              w_core_n  = w_adv_core;
              w_step_n  = w_adv_step;
              w_rel_n   = w_adv_rel;
              w_done_n  = w_adv_done;
            end
`else
            w_state_n = w_adv_state;
            w_core_n  = w_adv_core;
            w_step_n  = w_adv_step;
            w_rel_n   = w_adv_rel;
            w_done_n  = w_adv_done;
`endif
          end
        end else if (r_tmo == TMO_LAST) begin
          w_state_n    = ST_ERROR;
          w_error_n    = 1'b1;
          w_err_core_n = 4'(r_core);
        end else begin
          w_tmo_n = r_tmo + TMO_ONE;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  // State, counters and sticky status; reset aborts any sequence in flight.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state    <= ST_IDLE;
      r_core     <= '0;
      r_step     <= 3'd0;
      r_rel      <= 1'b0;
      r_rd       <= 1'b0;
      r_tmo      <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_core <= 4'd0;
    end else begin
      r_state    <= w_state_n;
      r_core     <= w_core_n;
      r_step     <= w_step_n;
      r_rel      <= w_rel_n;
      r_rd       <= w_rd_n;
      r_tmo      <= w_tmo_n;
      r_done     <= w_done_n;
      r_error    <= w_error_n;
      r_err_core <= w_err_core_n;
    end
  end

  // Capture boot PC and mode inputs when a start is accepted.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_npc <= '0;
      r_icm <= 2'd0;
      r_dcm <= 2'd0;
      r_ccm <= 1'b0;
    end else if (w_load) begin
      r_npc <= npc_i;
      r_icm <= icache_mode_i;
      r_dcm <= dcache_mode_i;
      r_ccm <= cce_mode_i;
    end else begin
      r_npc <= r_npc;
      r_icm <= r_icm;
      r_dcm <= r_dcm;
      r_ccm <= r_ccm;
    end
  end

  // Request fields come straight from registered state, so they hold while stalled.
  assign cfg.req_v_o    = (r_state == ST_ISSUE);
  assign cfg.req_addr_o = (AW'(r_core) << core_stride_lg_p) | w_off;
  assign cfg.req_data_o = w_data;
`ifdef ZP_CFG_SEQ_READBACK_EN
  assign cfg.req_w_o    = ~r_rd;
`else
  logic w_unused_rd;
  assign cfg.req_w_o    = 1'b1;
  assign w_unused_rd    = ^{cfg.resp_data_i, r_rd};
`endif
  // Every response is consumed; only those seen in WAIT have any effect.
  assign cfg.resp_yumi_o = aresetn & cfg.resp_v_i;

  assign busy_o     = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
  assign done_o     = r_done;
  assign error_o    = r_error;
  assign err_core_o = r_err_core;
endmodule

// File: tb/tb_zp_bp_cfg_boot_sequencer.sv
// Self-checking bench: expected cfg requests are queued when a start is
// driven and popped/compared as the slave model accepts each request.
`timescale 1ns/1ps
module tb_zp_bp_cfg_boot_sequencer;
  localparam int NC  = 2;
  localparam int AW  = 20;
  localparam int DW  = 64;
  localparam int TMO = 4096;
`ifdef ZP_CFG_SEQ_READBACK_EN
  localparam int N_REQ = 11 * NC;
`else
  localparam int N_REQ = 6 * NC;
`endif
  localparam int DONE_CYC = 2 * N_REQ + 1;
  localparam int NO_HOLD  = 1 << 30;

  logic        aclk = 1'b0;
  logic        aresetn, start_i;
  logic [63:0] npc_i;
  logic [1:0]  icache_mode_i, dcache_mode_i;
  logic        cce_mode_i;
  logic        busy_o, done_o, error_o;
  logic [3:0]  err_core_o;

  zp_bp_cfg_boot_sequencer_if #(.cfg_addr_width_p(AW), .cfg_data_width_p(DW)) cfg_if ();

  zp_bp_cfg_boot_sequencer #(.num_core_p(NC)) dut (
    .aclk(aclk), .aresetn(aresetn), .start_i(start_i), .npc_i(npc_i),
    .icache_mode_i(icache_mode_i), .dcache_mode_i(dcache_mode_i), .cce_mode_i(cce_mode_i),
    .cfg(cfg_if), .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_core_o(err_core_o)
  );

  always #5 aclk = ~aclk;

  typedef logic [84:0] req_t;  // {write, addr, data}
  req_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          hs_cnt = 0;
  int          hold_at = NO_HOLD;
  logic        bp_en = 1'b0;
  logic        corrupt = 1'b0;
  logic [19:0] err_addr = 20'hFFFFF;
  logic [63:0] mem [logic [19:0]];

  task automatic check_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Queue the requests a correct sequence makes; stop after the matching request.
  task automatic push_seq(input logic [19:0] stop_addr, input logic stop_w);
    logic [19:0] a;
    logic [63:0] d;
    for (int c = 0; c < NC; c++) begin
      for (int s = 0; s < 5; s++) begin
        case (s)
          0:       begin a = 20'h00008; d = 64'd1; end
          1:       begin a = 20'h00010; d = npc_i; end
          2:       begin a = 20'h00020; d = {62'd0, icache_mode_i}; end
          3:       begin a = 20'h00028; d = {62'd0, dcache_mode_i}; end
          default: begin a = 20'h00030; d = {63'd0, cce_mode_i}; end
        endcase
        a = a | (20'(c) << 16);
        exp_q.push_back({1'b1, a, d});
        if (stop_w && a == stop_addr) return;
`ifdef ZP_CFG_SEQ_READBACK_EN
        exp_q.push_back({1'b0, a, d});
        if (!stop_w && a == stop_addr) return;
`endif
      end
    end
    for (int c = 0; c < NC; c++) exp_q.push_back({1'b1, (20'(c) << 16) | 20'h00008, 64'd0});
  endtask

  // Pulse start and wait (bounded) for done or error; cyc counts negedges after the start edge.
  task automatic run_seq(input int budget, input logic restart, output int cyc);
    start_i = 1'b1;
    @(negedge aclk);
    start_i = 1'b0;
    cyc = 1;
    check_val("busy_after_start", 96'(busy_o), 96'd1);
    check_val("status_cleared", 96'({done_o, error_o}), 96'd0);
    while (!(done_o || error_o) && cyc < budget) begin
      @(negedge aclk);
      cyc++;
      start_i = restart && (cyc == 6);
    end
    start_i = 1'b0;
    if (!(done_o || error_o)) check_val("wait_bound", 96'(done_o | error_o), 96'd1);
  endtask

  // Slave model: random or zero-wait ready, one response per handshake, scoreboard pop.
  initial begin : slave
    logic        pend, gave, stalled, pend_err;
    int          pend_idx;
    logic [63:0] pend_rd, st_d;
    logic [19:0] st_a;
    pend = 1'b0; stalled = 1'b0; pend_idx = 0; pend_err = 1'b0; pend_rd = 64'd0;
    st_a = 20'd0; st_d = 64'd0;
    cfg_if.req_ready_and_i = 1'b0;
    cfg_if.resp_v_i = 1'b0; cfg_if.resp_err_i = 1'b0; cfg_if.resp_data_i = 64'd0;
    forever begin
      @(negedge aclk);
      gave = 1'b0;
      if (aresetn !== 1'b1) begin pend = 1'b0; stalled = 1'b0; end
      cfg_if.resp_v_i = 1'b0; cfg_if.resp_err_i = 1'b0; cfg_if.resp_data_i = 64'd0;
      if (pend && pend_idx < hold_at) begin
        cfg_if.resp_v_i = 1'b1; cfg_if.resp_err_i = pend_err; cfg_if.resp_data_i = pend_rd;
        pend = 1'b0; gave = 1'b1;
      end
      cfg_if.req_ready_and_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (gave) check_val("resp_yumi", 96'(cfg_if.resp_yumi_o), 96'd1);
      if (stalled && cfg_if.req_v_o) begin
        check_val("stall_addr", 96'(cfg_if.req_addr_o), 96'(st_a));
        check_val("stall_data", 96'(cfg_if.req_data_o), 96'(st_d));
      end
      if (cfg_if.req_v_o && cfg_if.req_ready_and_i) begin
        hs_cnt++;
        if (exp_q.size() == 0) check_val("req_unexpected", 96'(exp_q.size()), 96'd1);
        else check_val("req", 96'({cfg_if.req_w_o, cfg_if.req_addr_o, cfg_if.req_data_o}),
                       96'(exp_q.pop_front()));
        pend = 1'b1; pend_idx = hs_cnt;
        pend_err = cfg_if.req_w_o && (cfg_if.req_addr_o == err_addr);
        if (cfg_if.req_w_o) begin
          mem[cfg_if.req_addr_o] = cfg_if.req_data_o;
          pend_rd = 64'd0;
        end else begin
          pend_rd = mem.exists(cfg_if.req_addr_o) ? mem[cfg_if.req_addr_o] : 64'd0;
          if (corrupt && cfg_if.req_addr_o == 20'h00010) pend_rd = pend_rd ^ 64'd1;
        end
        stalled = 1'b0;
      end else begin
        stalled = cfg_if.req_v_o; st_a = cfg_if.req_addr_o; st_d = cfg_if.req_data_o;
      end
    end
  end

  initial begin : test
    int cyc, base;
    aresetn = 1'b0; start_i = 1'b0; npc_i = 64'd0;
    icache_mode_i = 2'd0; dcache_mode_i = 2'd0; cce_mode_i = 1'b0;
    repeat (3) @(negedge aclk);
    check_val("rst_outputs", 96'({cfg_if.req_v_o, busy_o, done_o, error_o, err_core_o}), 96'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);

    // Zero-wait slave: exact request list and completion latency.
    npc_i = 64'h8000_0000; icache_mode_i = 2'd2; dcache_mode_i = 2'd2; cce_mode_i = 1'b1;
    push_seq(20'hFFFFF, 1'b0);
    run_seq(200, 1'b0, cyc);
    check_val("t1_done_latency", 96'(cyc), 96'(DONE_CYC));
    check_val("t1_status", 96'({busy_o, done_o, error_o}), 96'b010);
    check_val("t1_sb_empty", 96'(exp_q.size()), 96'd0);
    repeat (3) @(negedge aclk);
    check_val("t1_done_sticky", 96'(done_o), 96'd1);

    // Random backpressure, plus a start pulse mid-sequence that must be ignored.
    bp_en = 1'b1;
    npc_i = {$urandom, $urandom}; icache_mode_i = 2'd1; dcache_mode_i = 2'd3; cce_mode_i = 1'b0;
    push_seq(20'hFFFFF, 1'b0);
    run_seq(2000, 1'b1, cyc);
    check_val("t2_status", 96'({busy_o, done_o, error_o}), 96'b010);
    check_val("t2_sb_empty", 96'(exp_q.size()), 96'd0);
    bp_en = 1'b0;

    // Error response on core 1, step S2.
    err_addr = 20'h10020;
    push_seq(20'h10020, 1'b1);
    run_seq(400, 1'b0, cyc);
    check_val("t3_status", 96'({busy_o, done_o, error_o}), 96'b001);
    check_val("t3_err_core", 96'(err_core_o), 96'd1);
    check_val("t3_sb_empty", 96'(exp_q.size()), 96'd0);
    repeat (5) @(negedge aclk);
    check_val("t3_no_req", 96'(cfg_if.req_v_o), 96'd0);
    err_addr = 20'hFFFFF;

    // Response withheld after the first handshake: timeout, then a late response.
    hold_at = hs_cnt + 1;
    push_seq(20'h00008, 1'b1);
    run_seq(TMO + 100, 1'b0, cyc);
    check_val("t4_tmo_latency", 96'(cyc), 96'(TMO + 2));
    check_val("t4_status", 96'({busy_o, done_o, error_o, err_core_o}), 96'b001_0000);
    hold_at = NO_HOLD;
    repeat (3) @(negedge aclk);
    check_val("t4_after_late", 96'({cfg_if.req_v_o, busy_o, done_o, error_o}), 96'b0001);
    check_val("t4_sb_empty", 96'(exp_q.size()), 96'd0);

    // Reset during the WAIT of the third write, then a clean restart.
    base = hs_cnt;
    hold_at = base + 3;
    push_seq(20'hFFFFF, 1'b0);
    start_i = 1'b1;
    @(negedge aclk);
    start_i = 1'b0;
    cyc = 0;
    while (hs_cnt < base + 3 && cyc < 100) begin
      @(negedge aclk);
      #2;
      cyc++;
    end
    check_val("t5_third_hs", 96'(hs_cnt - base), 96'd3);
    @(negedge aclk);
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    check_val("t5_rst_outputs",
              96'({cfg_if.req_v_o, busy_o, done_o, error_o, err_core_o, cfg_if.resp_yumi_o}), 96'd0);
    check_val("t5_sb_left", 96'(exp_q.size()), 96'(N_REQ - 3));
    exp_q.delete();
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    hold_at = NO_HOLD;
    @(negedge aclk);
    push_seq(20'hFFFFF, 1'b0);
    run_seq(200, 1'b0, cyc);
    check_val("t5_done_latency", 96'(cyc), 96'(DONE_CYC));
    check_val("t5_status", 96'({busy_o, done_o, error_o}), 96'b010);
    check_val("t5_sb_empty", 96'(exp_q.size()), 96'd0);

`ifdef ZP_CFG_SEQ_READBACK_EN
    // Corrupted npc readback on core 0.
    corrupt = 1'b1;
    base = hs_cnt;
    push_seq(20'h00010, 1'b0);
    run_seq(200, 1'b0, cyc);
    check_val("t6_req_count", 96'(hs_cnt - base), 96'd4);
    check_val("t6_status", 96'({busy_o, done_o, error_o, err_core_o}), 96'b001_0000);
    check_val("t6_sb_empty", 96'(exp_q.size()), 96'd0);
    corrupt = 1'b0;
`endif

    repeat (2) @(negedge aclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/zp_bp_cfg_boot_sequencer.md
Name: zp_bp_cfg_boot_sequencer

Overview:
Sequences BlackParrot cfg-bus writes that bring each core of the selected zynqparrot config out of reset. It sits between the PS-side host CSR shell and the BP cfg-bus/IO request path. Triggered by a host start pulse, it freezes and programs every core, then releases all cores. It keeps exactly one write outstanding and reports busy, done and error status back to the shell.

Parameters:
num_core_p, 1, number of cores to program (1..16)
cfg_addr_width_p, 20, cfg-bus address width
cfg_data_width_p, 64, cfg-bus data width
core_stride_lg_p, 16, log2 address stride between per-core cfg windows
freeze_addr_p, 'h0008, freeze register offset
npc_addr_p, 'h0010, boot-PC register offset
icache_mode_addr_p, 'h0020, icache mode offset
dcache_mode_addr_p, 'h0028, dcache mode offset
cce_mode_addr_p, 'h0030, cce mode offset
timeout_p, 4096, response timeout in cycles (at least 2)

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
start_i  in  1  one-cycle start pulse from host CSR
npc_i  in  cfg_data_width_p  boot PC, sampled on accepted start
icache_mode_i  in  2  icache mode, sampled on start
dcache_mode_i  in  2  dcache mode, sampled on start
cce_mode_i  in  1  cce mode, sampled on start
req_v_o  out  1  cfg request valid
req_w_o  out  1  1 = write, 0 = read
req_addr_o  out  cfg_addr_width_p  (core<<core_stride_lg_p) | offset
req_data_o  out  cfg_data_width_p  write data, zero-extended
req_ready_and_i  in  1  request accepted when high with req_v_o
resp_v_i  in  1  response valid
resp_err_i  in  1  response error flag
resp_data_i  in  cfg_data_width_p  read data
resp_yumi_o  out  1  response consumed
busy_o  out  1  sequence in progress
done_o  out  1  sticky: sequence completed
error_o  out  1  sticky: error or timeout
err_core_o  out  4  core index at first error

Behaviour:
- Reset (aresetn=0 at a clock edge): state IDLE. All outputs are 0. Sampled inputs and counters clear. A reset mid-sequence aborts the sequence with no further requests; the bench checks req_v_o=0 on the first cycle after reset.
- Step order per core c, for c = 0..num_core_p-1:
  - S0: freeze = 1
  - S1: npc
  - S2: icache_mode
  - S3: dcache_mode
  - S4: cce_mode
- Release phase: freeze = 0 written to cores 0..num_core_p-1 in order.
- Total writes: 6*num_core_p.
- FSM states: IDLE, ISSUE, WAIT, DONE, ERROR.
- IDLE: on start_i, sample mode inputs, clear done_o and error_o, go to ISSUE. busy_o = 1 in every state except IDLE, DONE and ERROR.
- ISSUE: req_v_o=1, held stable until req_ready_and_i. Address and data must not change while waiting. On handshake go to WAIT and clear the timeout counter.
- WAIT:
  - On resp_v_i, assert resp_yumi_o the same cycle (combinational).
  - resp_err_i=1: go to ERROR and latch err_core_o.
  - Otherwise advance the step. The last release write goes to DONE; any other step goes to ISSUE.
  - No response within timeout_p cycles of the handshake: go to ERROR.
- Responses arriving outside WAIT are consumed (resp_yumi_o=1) and ignored.
- DONE and ERROR: done_o=1 or error_o=1 respectively, sticky. start_i re-arms the sequence and goes straight to ISSUE.
- start_i while busy is ignored.
- Simultaneous start_i and aresetn=0: reset wins.
- Minimum per-write latency is 2 cycles (ISSUE then WAIT). A zero-wait slave therefore completes 6*N writes in 12*N cycles, plus 1 cycle to enter DONE.
- The step counter is 3 bits. The core counter is clog2(num_core_p+1) bits. Neither counter may wrap past num_core_p-1.

Optional Feature:
ZP_CFG_SEQ_READBACK_EN
- Defined: after each successful write (except release writes), issue a read (req_w_o=0) to the same address. Compare resp_data_i with the written data. A mismatch goes to ERROR.
- Total requests: 11*num_core_p.
- Undefined: req_w_o is tied to 1 and resp_data_i is unused.

Test Plan:
- N=1, npc=64'h8000_0000, modes 2/2/1, ready and resp always high -> writes to 0x0008=1, 0x0010=0x80000000, 0x0020=2, 0x0028=2, 0x0030=1, then 0x0008=0. done_o is set 13 cycles after start.
- N=2 with random req_ready_and_i backpressure -> 12 writes. Core-1 addresses are 0x10008 etc. req_addr_o and req_data_o stay stable while stalled.
- resp_err_i=1 on core 1, step S2 -> error_o=1, err_core_o=1, no further requests, done_o=0.
- Withhold the response for 4096 cycles after a handshake -> error_o=1 after the timeout; a late response is then yumi'd and ignored.
- aresetn low during the 3rd write's WAIT -> all outputs 0. A fresh start_i then restarts from core 0, S0.
- With READBACK_EN, a corrupted readback of npc -> error_o=1 after the 4th request.
